// File: rtl/irq_source_arbiter.sv
// ---------------------------------------------------------------------------
// irq_source_arbiter
//
// Captures peripheral interrupt lines into a pending register, picks the
// lowest-index eligible source and presents one registered request to the
// core interrupt controller. The controller's take (irq_i) and return
// (irq_ret_i) pulses drive the service handshake. On return, the serviced
// peripheral gets a one-cycle acknowledge and its pending bit is cleared.
//
// Ports
//   clk_i        clock, rising-edge
//   rst_i        synchronous active-high reset
//   src_i        raw interrupt lines (N_SRC), synchronous to clk_i
//   edge_mask_i  per source: 1 = rising-edge sensitive, 0 = level sensitive
//   en_mask_i    per-source enable
//   irq_i        take pulse from the interrupt controller
//   irq_ret_i    return pulse from the interrupt controller
//   irq_req_o    registered request to the interrupt controller
//   irq_id_o     index of the selected / in-service source
//   src_ack_o    one-hot, one-cycle acknowledge to the serviced peripheral
//   pending_o    pending register readback
//   busy_o       FSM not idle
//
// State table
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no request outstanding; arbitrate eligible pending sources
//   ST_REQ     | request raised for irq_id_o, waiting for the take pulse
//   ST_SERVICE | controller is servicing irq_id_o, waiting for the return
// ---------------------------------------------------------------------------
module irq_source_arbiter #(
  parameter int N_SRC = 16,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] src_i,
  input  logic [N_SRC-1:0] edge_mask_i,
  input  logic [N_SRC-1:0] en_mask_i,
  input  logic             irq_i,
  input  logic             irq_ret_i,
  output logic             irq_req_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic [N_SRC-1:0] src_ack_o,
  output logic [N_SRC-1:0] pending_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [N_SRC-1:0] src_prev_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] ack_q;
  logic [N_SRC-1:0] ack_d;
  logic [ID_W-1:0]  id_q;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] clr_vec;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] id_onehot;
  logic [ID_W-1:0]  winner;
  logic             any_eligible;
  logic             id_enabled;
  logic             ret_fire;

  // -------------------------------------------------------------------------
  // Pending capture
  // -------------------------------------------------------------------------
  assign rise    = src_i & ~src_prev_q;
  assign set_vec = en_mask_i & ((edge_mask_i & rise) | (~edge_mask_i & src_i));

  // Decoded in-service id, shared by the enable check and the acknowledge.
  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      id_onehot[i] = (id_q == ID_W'(i));
    end
  end

  assign ret_fire   = (state_q == ST_SERVICE) && irq_ret_i;
  assign clr_vec    = ret_fire ? id_onehot : '0;
  assign ack_d      = clr_vec;
  assign id_enabled = |(en_mask_i & id_onehot);

  // On a same-cycle set and clear an edge source keeps its new edge, while a
  // level source is dropped and simply re-sampled on the following cycle.
  assign pending_d = (pending_q & ~clr_vec)
                   | (set_vec & ~(clr_vec & ~edge_mask_i));

  // -------------------------------------------------------------------------
  // Fixed-priority arbitration: lowest eligible index wins
  // -------------------------------------------------------------------------
  assign eligible     = pending_q & en_mask_i;
  assign any_eligible = |eligible;

  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Disabling the selected source withdraws the request but keeps it
        // pending; this takes precedence over a simultaneous take pulse.
        if (!id_enabled) begin
          state_d = ST_IDLE;
        end else if (irq_i) begin
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (irq_ret_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs, decoded from the state register only
  // -------------------------------------------------------------------------
  always_comb begin
    irq_req_o = (state_q == ST_REQ);
    busy_o    = (state_q != ST_IDLE);
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_prev_q <= '0;
      pending_q  <= '0;
      ack_q      <= '0;
      id_q       <= '0;
    end else begin
      src_prev_q <= src_i;
      pending_q  <= pending_d;
      ack_q      <= ack_d;
      // The id is captured only when leaving IDLE, so it stays locked from
      // REQ entry through the acknowledge cycle.
      if ((state_q == ST_IDLE) && any_eligible) begin
        id_q <= winner;
      end
    end
  end

  assign irq_id_o  = id_q;
  assign src_ack_o = ack_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_irq_source_arbiter.sv
module tb_irq_source_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] src_i;
  logic [15:0] edge_mask_i;
  logic [15:0] en_mask_i;
  logic        irq_i;
  logic        irq_ret_i;
  logic        irq_req_o;
  logic [3:0]  irq_id_o;
  logic [15:0] src_ack_o;
  logic [15:0] pending_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  irq_source_arbiter #(.N_SRC(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .src_i       (src_i),
    .edge_mask_i (edge_mask_i),
    .en_mask_i   (en_mask_i),
    .irq_i       (irq_i),
    .irq_ret_i   (irq_ret_i),
    .irq_req_o   (irq_req_o),
    .irq_id_o    (irq_id_o),
    .src_ack_o   (src_ack_o),
    .pending_o   (pending_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Take in the current (REQ) cycle, return in the next; ends in the ack cycle.
  task automatic serve();
    irq_i = 1'b1;
    tick();
    irq_i = 1'b0;
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    src_i = 16'hFFFF;
    tick();
    tick();
    n_checks++; if (irq_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", irq_req_o); end
    n_checks++; if (irq_id_o !== 4'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", irq_id_o); end
    n_checks++; if (src_ack_o !== 16'h0000) begin n_fail++; $display("FAIL reset_ack: got %h expected 0000", src_ack_o); end
    n_checks++; if (pending_o !== 16'h0000) begin n_fail++; $display("FAIL reset_pending: got %h expected 0000", pending_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    rst_i = 1'b0;
    tick();
    n_checks++; if (pending_o !== 16'hFFFF) begin n_fail++; $display("FAIL reset_edge_pending: got %h expected ffff", pending_o); end
    n_checks++; if (irq_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_c1: got %b expected 0", irq_req_o); end
    tick();
    n_checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 4'd0) begin n_fail++; $display("FAIL reset_first_req: got req=%b id=%0d expected req=1 id=0", irq_req_o, irq_id_o); end
    rst_i = 1'b1;
    src_i = 16'h0000;
    tick();
    rst_i = 1'b0;
    tick();
    n_checks++; if (pending_o !== 16'h0000 || busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_clean: got pending=%h busy=%b expected 0000/0", pending_o, busy_o); end
  endtask

  task automatic test_single_edge();
    src_i = 16'h0008;
    tick();
    src_i = 16'h0000;
    n_checks++; if (pending_o !== 16'h0008) begin n_fail++; $display("FAIL single_pending: got %h expected 0008", pending_o); end
    n_checks++; if (irq_req_o !== 1'b0) begin n_fail++; $display("FAIL single_req_early: got %b expected 0", irq_req_o); end
    tick();
    n_checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 4'd3) begin n_fail++; $display("FAIL single_req: got req=%b id=%0d expected req=1 id=3", irq_req_o, irq_id_o); end
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    n_checks++; if (irq_req_o !== 1'b1 || src_ack_o !== 16'h0000) begin n_fail++; $display("FAIL single_ret_in_req: got req=%b ack=%h expected req=1 ack=0000", irq_req_o, src_ack_o); end
    irq_i = 1'b1;
    tick();
    irq_i = 1'b0;
    n_checks++; if (irq_req_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL single_take: got req=%b busy=%b expected req=0 busy=1", irq_req_o, busy_o); end
    tick();
    n_checks++; if (busy_o !== 1'b1 || src_ack_o !== 16'h0000) begin n_fail++; $display("FAIL single_service_wait: got busy=%b ack=%h expected busy=1 ack=0000", busy_o, src_ack_o); end
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    n_checks++; if (src_ack_o !== 16'h0008) begin n_fail++; $display("FAIL single_ack: got %h expected 0008", src_ack_o); end
    n_checks++; if (pending_o !== 16'h0000 || busy_o !== 1'b0 || irq_id_o !== 4'd3) begin n_fail++; $display("FAIL single_ack_state: got pending=%h busy=%b id=%0d expected 0000/0/3", pending_o, busy_o, irq_id_o); end
    tick();
    n_checks++; if (src_ack_o !== 16'h0000 || irq_req_o !== 1'b0) begin n_fail++; $display("FAIL single_ack_once: got ack=%h req=%b expected 0000/0", src_ack_o, irq_req_o); end
  endtask

  task automatic test_priority();
    src_i = 16'h0024;
    tick();
    src_i = 16'h0000;
    n_checks++; if (pending_o !== 16'h0024) begin n_fail++; $display("FAIL prio_pending: got %h expected 0024", pending_o); end
    tick();
    n_checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 4'd2) begin n_fail++; $display("FAIL prio_winner: got req=%b id=%0d expected req=1 id=2", irq_req_o, irq_id_o); end
    src_i = 16'h0001;
    tick();
    src_i = 16'h0000;
    n_checks++; if (irq_id_o !== 4'd2 || pending_o !== 16'h0025) begin n_fail++; $display("FAIL prio_lock: got id=%0d pending=%h expected id=2 pending=0025", irq_id_o, pending_o); end
    tick();
    n_checks++; if (irq_id_o !== 4'd2 || irq_req_o !== 1'b1) begin n_fail++; $display("FAIL prio_lock_hold: got id=%0d req=%b expected id=2 req=1", irq_id_o, irq_req_o); end
    serve();
    n_checks++; if (src_ack_o !== 16'h0004 || pending_o !== 16'h0021) begin n_fail++; $display("FAIL prio_ack2: got ack=%h pending=%h expected 0004/0021", src_ack_o, pending_o); end
    tick();
    n_checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 4'd0) begin n_fail++; $display("FAIL prio_next0: got req=%b id=%0d expected req=1 id=0", irq_req_o, irq_id_o); end
    serve();
    n_checks++; if (src_ack_o !== 16'h0001 || pending_o !== 16'h0020) begin n_fail++; $display("FAIL prio_ack0: got ack=%h pending=%h expected 0001/0020", src_ack_o, pending_o); end
    tick();
    n_checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 4'd5) begin n_fail++; $display("FAIL prio_next5: got req=%b id=%0d expected req=1 id=5", irq_req_o, irq_id_o); end
    serve();
    n_checks++; if (src_ack_o !== 16'h0020 || pending_o !== 16'h0000) begin n_fail++; $display("FAIL prio_ack5: got ack=%h pending=%h expected 0020/0000", src_ack_o, pending_o); end
    tick();
  endtask

  task automatic test_level();
    edge_mask_i = 16'hFF7F;
    src_i = 16'h0080;
    tick();
    n_checks++; if (pending_o !== 16'h0080) begin n_fail++; $display("FAIL level_pending: got %h expected 0080", pending_o); end
    tick();
    n_checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 4'd7) begin n_fail++; $display("FAIL level_req: got req=%b id=%0d expected req=1 id=7", irq_req_o, irq_id_o); end
    serve();
    n_checks++; if (src_ack_o !== 16'h0080 || pending_o !== 16'h0000) begin n_fail++; $display("FAIL level_ack_clear: got ack=%h pending=%h expected 0080/0000", src_ack_o, pending_o); end
    tick();
    n_checks++; if (pending_o !== 16'h0080 || irq_req_o !== 1'b0) begin n_fail++; $display("FAIL level_resample: got pending=%h req=%b expected 0080/0", pending_o, irq_req_o); end
    tick();
    n_checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 4'd7) begin n_fail++; $display("FAIL level_rereq: got req=%b id=%0d expected req=1 id=7", irq_req_o, irq_id_o); end
    src_i = 16'h0000;
    serve();
    n_checks++; if (src_ack_o !== 16'h0080) begin n_fail++; $display("FAIL level_ack2: got %h expected 0080", src_ack_o); end
    tick();
    n_checks++; if (pending_o !== 16'h0000 || busy_o !== 1'b0) begin n_fail++; $display("FAIL level_done: got pending=%h busy=%b expected 0000/0", pending_o, busy_o); end
    edge_mask_i = 16'hFFFF;
  endtask

  task automatic test_edge_during_ack();
    src_i = 16'h0010;
    tick();
    src_i = 16'h0000;
    tick();
    n_checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 4'd4) begin n_fail++; $display("FAIL edgeack_req: got req=%b id=%0d expected req=1 id=4", irq_req_o, irq_id_o); end
    irq_i = 1'b1;
    tick();
    irq_i = 1'b0;
    irq_ret_i = 1'b1;
    src_i = 16'h0010;
    tick();
    irq_ret_i = 1'b0;
    src_i = 16'h0000;
    n_checks++; if (src_ack_o !== 16'h0010 || pending_o !== 16'h0010) begin n_fail++; $display("FAIL edgeack_keep: got ack=%h pending=%h expected 0010/0010", src_ack_o, pending_o); end
    tick();
    n_checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 4'd4 || src_ack_o !== 16'h0000) begin n_fail++; $display("FAIL edgeack_rereq: got req=%b id=%0d ack=%h expected 1/4/0000", irq_req_o, irq_id_o, src_ack_o); end
    serve();
    n_checks++; if (src_ack_o !== 16'h0010 || pending_o !== 16'h0000) begin n_fail++; $display("FAIL edgeack_ack2: got ack=%h pending=%h expected 0010/0000", src_ack_o, pending_o); end
    tick();
  endtask

  task automatic test_disable();
    en_mask_i = 16'hFDFF;
    src_i = 16'h0200;
    tick();
    src_i = 16'h0000;
    n_checks++; if (pending_o !== 16'h0000) begin n_fail++; $display("FAIL disabled_no_set: got %h expected 0000", pending_o); end
    tick();
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL disabled_idle: got busy=%b expected 0", busy_o); end
    en_mask_i = 16'hFFFF;
    src_i = 16'h0040;
    tick();
    src_i = 16'h0000;
    tick();
    n_checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 4'd6) begin n_fail++; $display("FAIL dis_req: got req=%b id=%0d expected req=1 id=6", irq_req_o, irq_id_o); end
    en_mask_i = 16'hFFBF;
    tick();
    n_checks++; if (irq_req_o !== 1'b0 || busy_o !== 1'b0 || pending_o !== 16'h0040) begin n_fail++; $display("FAIL dis_withdraw: got req=%b busy=%b pending=%h expected 0/0/0040", irq_req_o, busy_o, pending_o); end
    tick();
    n_checks++; if (irq_req_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL dis_excluded: got req=%b busy=%b expected 0/0", irq_req_o, busy_o); end
    en_mask_i = 16'hFFFF;
    tick();
    n_checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 4'd6) begin n_fail++; $display("FAIL dis_reenable: got req=%b id=%0d expected req=1 id=6", irq_req_o, irq_id_o); end
    serve();
    n_checks++; if (src_ack_o !== 16'h0040 || pending_o !== 16'h0000) begin n_fail++; $display("FAIL dis_ack: got ack=%h pending=%h expected 0040/0000", src_ack_o, pending_o); end
    tick();
  endtask

  task automatic test_ignored();
    irq_i = 1'b1;
    irq_ret_i = 1'b1;
    tick();
    irq_i = 1'b0;
    irq_ret_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0 || src_ack_o !== 16'h0000) begin n_fail++; $display("FAIL ignored_idle: got busy=%b ack=%h expected 0/0000", busy_o, src_ack_o); end
    tick();
    n_checks++; if (irq_req_o !== 1'b0 || src_ack_o !== 16'h0000) begin n_fail++; $display("FAIL ignored_idle2: got req=%b ack=%h expected 0/0000", irq_req_o, src_ack_o); end
  endtask

  task automatic test_reset_in_service();
    src_i = 16'h0002;
    tick();
    src_i = 16'h0000;
    tick();
    irq_i = 1'b1;
    tick();
    irq_i = 1'b0;
    n_checks++; if (busy_o !== 1'b1 || irq_id_o !== 4'd1) begin n_fail++; $display("FAIL rst_svc_setup: got busy=%b id=%0d expected 1/1", busy_o, irq_id_o); end
    irq_ret_i = 1'b1;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    irq_ret_i = 1'b0;
    n_checks++; if (src_ack_o !== 16'h0000 || pending_o !== 16'h0000 || busy_o !== 1'b0 || irq_id_o !== 4'd0) begin n_fail++; $display("FAIL rst_svc: got ack=%h pending=%h busy=%b id=%0d expected 0000/0000/0/0", src_ack_o, pending_o, busy_o, irq_id_o); end
    tick();
    n_checks++; if (src_ack_o !== 16'h0000 || irq_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_svc_after: got ack=%h req=%b expected 0000/0", src_ack_o, irq_req_o); end
  endtask

  initial begin
    rst_i       = 1'b0;
    src_i       = 16'h0000;
    edge_mask_i = 16'hFFFF;
    en_mask_i   = 16'hFFFF;
    irq_i       = 1'b0;
    irq_ret_i   = 1'b0;
    #2;
    test_reset();
    test_single_edge();
    test_priority();
    test_level();
    test_edge_during_ack();
    test_disable();
    test_ignored();
    test_reset_in_service();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_source_arbiter.md
# irq_source_arbiter

Collects peripheral interrupt lines, latches them as pending, selects one by fixed priority and presents a single registered request to the core's interrupt controller. It sits directly upstream of the interrupt controller. Its `irq_req_o` drives that controller's request input. The controller's take pulse (`irq_o`) and return pulse (`irq_ret_o`) come back here, so the arbiter knows which source is in service and when to acknowledge it.

## Interface
- `N_SRC`, default 16: number of peripheral interrupt sources (2..32).
- `ID_W`, default `$clog2(N_SRC)`: width of the source index.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `src_i`  in  N_SRC  raw peripheral interrupt lines, synchronous to `clk_i`.
- `edge_mask_i`  in  N_SRC  per source: 1 = rising-edge sensitive, 0 = level sensitive.
- `en_mask_i`  in  N_SRC  per-source enable.
- `irq_i`  in  1  take pulse from the interrupt controller (its `irq_o`).
- `irq_ret_i`  in  1  return pulse from the interrupt controller (its `irq_ret_o`).
- `irq_req_o`  out  1  request to the interrupt controller; registered.
- `irq_id_o`  out  ID_W  index of the source currently selected or in service.
- `src_ack_o`  out  N_SRC  one-hot, one-cycle acknowledge to the serviced peripheral.
- `pending_o`  out  N_SRC  pending register, for CSR readback.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
**Pending capture**
- `src_prev` register holds last cycle's `src_i`; `rise = src_i & ~src_prev`.
- Set condition for `pending[k]`: `en_mask_i[k] & (edge_mask_i[k] ? rise[k] : src_i[k])`.
- Clear condition for `pending[k]`: ack of source k (see SERVICE).
- Same-cycle set and clear, edge source: set wins, so a new edge is not lost.
- Same-cycle set and clear, level source: clear wins; the line is re-sampled the next cycle.
- A disabled source never sets pending. Existing pending bits are retained but excluded from arbitration.

**Arbitration**
- Eligible set: `pending & en_mask_i`.
- Winner: lowest eligible index.

**FSM states**
- IDLE
  - If any source is eligible: latch the winner into `irq_id_o` and go to REQ.
- REQ
  - Outputs: `irq_req_o` = 1.
  - The selected id is locked; a higher-priority source arriving later does not preempt it.
  - If `en_mask_i[irq_id_o]` = 0: go to IDLE (request withdrawn, pending kept).
  - Else if `irq_i` = 1: go to SERVICE.
- SERVICE
  - Outputs: `irq_req_o` = 0.
  - On `irq_ret_i` = 1: at the same edge, set `src_ack_o[irq_id_o]` = 1 for one cycle, clear `pending[irq_id_o]`, and go to IDLE.

**Ignored inputs**
- `irq_ret_i` outside SERVICE is ignored.
- `irq_i` outside REQ is ignored.

**Outputs**
- `irq_req_o` is a registered state decode, so there is no combinational path from `irq_i` or `irq_ret_i`.
- `busy_o` = state != IDLE.

## Timing
**Reset values**
- State IDLE.
- `pending_o` = 0, `src_prev` = 0.
- `irq_req_o` = 0, `irq_id_o` = 0, `src_ack_o` = 0, `busy_o` = 0.
- An edge source that is high in the first cycle after reset counts as a rising edge.

**Latencies**
- `src_i[k]` qualifies in cycle c → `pending_o[k]` = 1 in c+1 → `irq_req_o` = 1 and `irq_id_o` = k in c+2.
- `irq_i` in cycle c, state REQ → `irq_req_o` = 0 in c+1.
- `irq_ret_i` in cycle c, state SERVICE → in c+1: `src_ack_o` one-hot, pending bit cleared, state IDLE.
  - The earliest following request is `irq_req_o` = 1 in c+2.
  - Arbitration in c+1 uses the already-cleared pending value.
- `en_mask_i[id]` falls in cycle c, state REQ → `irq_req_o` = 0 in c+1.

**Holds**
- `irq_id_o` holds from entry into REQ through the ack cycle.
- Reset asserted in any state returns all registers to reset values at the next edge. No ack is issued.

## Test plan
1. **Reset:** hold `rst_i` 2 cycles with `src_i` = 0xFFFF → all outputs 0. After release, edge sources register as pending.
2. **Single edge source:** one-cycle pulse on `src_i[3]`, edge mode, at cycle c.
   - `pending_o` = 0x0008 at c+1.
   - `irq_req_o` = 1, `irq_id_o` = 3 at c+2.
   - `irq_i` pulse → `irq_req_o` drops the next cycle.
   - `irq_ret_i` → `src_ack_o` = 0x0008 for exactly 1 cycle, `pending_o` = 0.
3. **Priority and lock:** edges on sources 5 and 2 in the same cycle → `irq_id_o` = 2. During REQ for 2, raise source 0 → no preemption. After 2 is acked, source 0 is serviced next, then 5, with no new edges needed.
4. **Level re-request:** level source 7 held high through its ack → `pending_o[7]` = 0 in the ack cycle, 1 in the next cycle, and a second request with `irq_id_o` = 7 follows.
5. **Edge during ack:** edge source 4 is serviced and a new rising edge on `src_i[4]` lands in the `irq_ret_i` cycle → `pending_o[4]` stays 1 and a second request follows.
6. **Disable in REQ:** clear `en_mask_i[6]` while requesting id 6 → `irq_req_o` = 0 the next cycle, `busy_o` = 0, `pending_o[6]` = 1. Re-enable → request again with `irq_id_o` = 6.
